// File: rtl/card_turn_controller.sv
// Turn sequencer for the 6x6 memory game: accepts two picks, fetches both card
// values from the card RAM, compares them and keeps masks, scores and turn order.
module card_turn_controller #(
    parameter int NUM_CARDS   = 36,
    parameter int IDX_W       = 6,
    parameter int VAL_W       = 5,
    parameter int NUM_PAIRS   = 18,
    parameter int SHOW_CYCLES = 50
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 select,
    input  logic                 restart,
    input  logic [IDX_W-1:0]     cursor,
    output logic [IDX_W-1:0]     rd_addr,
    input  logic [VAL_W-1:0]     rd_data,
    output logic [VAL_W-1:0]     data1,
    output logic [VAL_W-1:0]     data2,
    output logic [NUM_CARDS-1:0] face_up,
    output logic [NUM_CARDS-1:0] matched,
    output logic [4:0]           pairs_found,
    output logic [4:0]           score0,
    output logic [4:0]           score1,
    output logic                 player,
    output logic                 pair_found,
    output logic                 mismatch,
    output logic                 busy,
    output logic                 game_over
);

    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

    typedef enum logic [3:0] {
        PICK1, READ1, CAP1, PICK2, READ2, CAP2, COMPARE, SHOW, OVER
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx1, idx2;
    logic [CNT_W-1:0] show_cnt;
    logic             legal_pick;
    logic             is_match;
    logic             last_pair;
    logic             show_done;

    always_comb begin
        legal_pick = 1'b0;
        if (select && (cursor < IDX_W'(NUM_CARDS)) && !matched[cursor]) begin
            legal_pick = (state == PICK1) || ((state == PICK2) && (cursor != idx1));
        end
    end

    assign is_match  = (data1 == data2);
    assign last_pair = (pairs_found == 5'(NUM_PAIRS - 1));
    assign show_done = (show_cnt == '0);
    assign busy      = !((state == PICK1) || (state == PICK2));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= PICK1;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            PICK1:   if (legal_pick) state_next = READ1;
            READ1:   state_next = CAP1;
            CAP1:    state_next = PICK2;
            PICK2:   if (legal_pick) state_next = READ2;
            READ2:   state_next = CAP2;
            CAP2:    state_next = COMPARE;
            COMPARE: begin
                if (is_match) state_next = last_pair ? OVER : PICK1;
                else          state_next = SHOW;
            end
            SHOW:    if (show_done) state_next = PICK1;
            OVER:    state_next = OVER;
            default: state_next = PICK1;
        endcase
        if (restart) state_next = PICK1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx1        <= '0;
            idx2        <= '0;
            rd_addr     <= '0;
            data1       <= '0;
            data2       <= '0;
            face_up     <= '0;
            matched     <= '0;
            pairs_found <= '0;
            score0      <= '0;
            score1      <= '0;
            player      <= 1'b0;
            pair_found  <= 1'b0;
            mismatch    <= 1'b0;
            game_over   <= 1'b0;
            show_cnt    <= '0;
        end else if (restart) begin
            idx1        <= '0;
            idx2        <= '0;
            rd_addr     <= '0;
            data1       <= '0;
            data2       <= '0;
            face_up     <= '0;
            matched     <= '0;
            pairs_found <= '0;
            score0      <= '0;
            score1      <= '0;
            player      <= 1'b0;
            pair_found  <= 1'b0;
            mismatch    <= 1'b0;
            game_over   <= 1'b0;
            show_cnt    <= '0;
        end else begin
            pair_found <= 1'b0;
            mismatch   <= 1'b0;
            game_over  <= (state_next == OVER);
            case (state)
                PICK1: if (legal_pick) begin
                    idx1    <= cursor;
                    rd_addr <= cursor;
                end
                CAP1: begin
                    data1         <= rd_data;
                    face_up[idx1] <= 1'b1;
                end
                PICK2: if (legal_pick) begin
                    idx2    <= cursor;
                    rd_addr <= cursor;
                end
                CAP2: begin
                    data2         <= rd_data;
                    face_up[idx2] <= 1'b1;
                end
                COMPARE: begin
                    if (is_match) begin
                        // face_up bits stay set; they are now owned by matched
                        matched[idx1] <= 1'b1;
                        matched[idx2] <= 1'b1;
                        pair_found    <= 1'b1;
                        if (pairs_found < 5'(NUM_PAIRS)) begin
                            pairs_found <= pairs_found + 5'd1;
                            if (player) score1 <= score1 + 5'd1;
                            else        score0 <= score0 + 5'd1;
                        end
                    end else begin
                        mismatch <= 1'b1;
                        show_cnt <= CNT_W'(SHOW_CYCLES - 1);
                    end
                end
                SHOW: begin
                    if (show_done) begin
                        face_up[idx1] <= 1'b0;
                        face_up[idx2] <= 1'b0;
                        player        <= ~player;
                    end else begin
                        show_cnt <= show_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_turn_controller.sv
// Bench for card_turn_controller: directed turns against a board image; a
// scoreboard queue holds the expected result of every compare pulse.
module tb_card_turn_controller;

    logic        clock, reset_n, select, restart;
    logic [5:0]  cursor, rd_addr;
    logic [4:0]  rd_data, data1, data2;
    logic [35:0] face_up, matched;
    logic [4:0]  pairs_found, score0, score1;
    logic        player, pair_found, mismatch, busy, game_over;

    card_turn_controller #(.NUM_CARDS(36), .IDX_W(6), .VAL_W(5), .NUM_PAIRS(18), .SHOW_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .select(select), .restart(restart), .cursor(cursor),
        .rd_addr(rd_addr), .rd_data(rd_data), .data1(data1), .data2(data2), .face_up(face_up),
        .matched(matched), .pairs_found(pairs_found), .score0(score0), .score1(score1),
        .player(player), .pair_found(pair_found), .mismatch(mismatch), .busy(busy),
        .game_over(game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // card RAM: one register stage, so data is valid in the 2nd cycle after rd_addr changes
    logic [4:0] mem [0:35];
    logic [4:0] rd_q;
    always @(posedge clock) rd_q <= (rd_addr < 6'd36) ? mem[rd_addr] : 5'd0;
    assign rd_data = rd_q;

    typedef struct {
        logic        pf;
        logic [4:0]  d1, d2;
        logic [35:0] m, fu;
        logic [4:0]  pairs, s0, s1;
        logic        pl, go;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int failures = 0;

    logic [35:0] m_matched;
    logic [4:0]  m_pairs, m_s0, m_s1;
    logic        m_player;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_rd_addr"}, 64'(rd_addr), 0);
        chk({nm, "_data1"}, 64'(data1), 0);
        chk({nm, "_data2"}, 64'(data2), 0);
        chk({nm, "_face_up"}, 64'(face_up), 0);
        chk({nm, "_matched"}, 64'(matched), 0);
        chk({nm, "_pairs"}, 64'(pairs_found), 0);
        chk({nm, "_score0"}, 64'(score0), 0);
        chk({nm, "_score1"}, 64'(score1), 0);
        chk({nm, "_player"}, 64'(player), 0);
        chk({nm, "_pulses"}, 64'({pair_found, mismatch}), 0);
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_game_over"}, 64'(game_over), 0);
    endtask

    task automatic model_clear();
        m_matched = '0; m_pairs = '0; m_s0 = '0; m_s1 = '0; m_player = 1'b0;
    endtask

    // expected outcome of picking a then b, observed in the cycle after COMPARE
    task automatic push_turn(input int a, input int b);
        exp_t e;
        e.pf = (mem[a] == mem[b]);
        e.d1 = mem[a];
        e.d2 = mem[b];
        e.pl = m_player;
        if (e.pf) begin
            m_matched[a] = 1'b1;
            m_matched[b] = 1'b1;
            m_pairs = m_pairs + 5'd1;
            if (m_player) m_s1 = m_s1 + 5'd1;
            else          m_s0 = m_s0 + 5'd1;
            e.fu = m_matched;
        end else begin
            e.fu = m_matched;
            e.fu[a] = 1'b1;
            e.fu[b] = 1'b1;
        end
        e.m = m_matched;
        e.pairs = m_pairs;
        e.s0 = m_s0;
        e.s1 = m_s1;
        e.go = e.pf && (m_pairs == 5'd18);
        sbq.push_back(e);
        if (!e.pf) m_player = ~m_player;
    endtask

    always @(negedge clock) begin
        if (reset_n && (pair_found || mismatch)) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=%0b%0b expected=none", pair_found, mismatch);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_kind", 64'({pair_found, mismatch}), 64'({e.pf, !e.pf}));
                chk("sb_data1", 64'(data1), 64'(e.d1));
                chk("sb_data2", 64'(data2), 64'(e.d2));
                chk("sb_matched", 64'(matched), 64'(e.m));
                chk("sb_face_up", 64'(face_up), 64'(e.fu));
                chk("sb_pairs", 64'(pairs_found), 64'(e.pairs));
                chk("sb_scores", 64'({score0, score1}), 64'({e.s0, e.s1}));
                chk("sb_player", 64'(player), 64'(e.pl));
                chk("sb_game_over", 64'(game_over), 64'(e.go));
            end
        end
    end

    task automatic pick(input int c);
        @(negedge clock);
        cursor = 6'(c);
        select = 1'b1;
        @(negedge clock);
        select = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (busy && !game_over && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=busy expected=ready", nm);
        end
    endtask

    task automatic wait_mismatch(input string nm);
        int n = 0;
        while (!mismatch && n < 10) begin
            @(negedge clock);
            n++;
        end
        if (n >= 10) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_pulse expected=mismatch", nm);
        end
    endtask

    task automatic turn(input int a, input int b);
        push_turn(a, b);
        pick(a);
        wait_ready("turn_a");
        pick(b);
        wait_ready("turn_b");
    endtask

    // a pick that must be ignored while the FSM waits for a pick
    task automatic illegal(input int c, input string nm);
        logic [5:0]  a0;
        logic [35:0] f0;
        a0 = rd_addr;
        f0 = face_up;
        @(negedge clock);
        cursor = 6'(c);
        select = 1'b1;
        @(posedge clock);
        #1;
        chk({nm, "_busy"}, 64'(busy), 0);
        chk({nm, "_rd_addr"}, 64'(rd_addr), 64'(a0));
        chk({nm, "_face_up"}, 64'(face_up), 64'(f0));
        @(negedge clock);
        select = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    int pa[16], pb[16];

    initial begin
        int cnt;
        for (int j = 0; j < 15; j++) begin
            mem[5 + j]  = 5'(10 + j);
            mem[21 + j] = 5'(10 + j);
        end
        mem[3] = 5'd7; mem[20] = 5'd7;
        mem[0] = 5'd5; mem[2]  = 5'd5;
        mem[1] = 5'd9; mem[4]  = 5'd9;
        pa[0] = 1; pb[0] = 4;
        for (int k = 1; k < 16; k++) begin
            pa[k] = 4 + k;
            pb[k] = 20 + k;
        end
        model_clear();

        reset_n = 1'b0; select = 1'b0; restart = 1'b0; cursor = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_cleared("reset");

        // first pick doubles as the latency check: accept edge k, capture at k+2
        push_turn(3, 20);
        @(negedge clock);
        cursor = 6'd3;
        select = 1'b1;
        @(posedge clock);
        #1;
        chk("lat_rd_addr_k", 64'(rd_addr), 3);
        chk("lat_busy_k", 64'(busy), 1);
        @(negedge clock);
        select = 1'b0;
        @(posedge clock);
        #1;
        chk("lat_data1_k1", 64'(data1), 0);
        chk("lat_face_up_k1", 64'(face_up), 0);
        @(posedge clock);
        #1;
        chk("lat_data1_k2", 64'(data1), 7);
        chk("lat_face_up_k2", 64'(face_up), 64'(36'd1 << 3));
        wait_ready("lat");
        pick(20);
        wait_ready("match1");
        chk("match1_player", 64'(player), 0);
        chk("match1_face_up", 64'(face_up), 64'((36'd1 << 3) | (36'd1 << 20)));

        // mismatch: both cards shown for exactly SHOW_CYCLES cycles
        push_turn(0, 1);
        pick(0);
        wait_ready("mis1_a");
        pick(1);
        wait_mismatch("mis1");
        cnt = 0;
        while (face_up[0] && face_up[1] && cnt < 20) begin
            cnt++;
            @(negedge clock);
        end
        chk("show_cycles", 64'(cnt), 4);
        chk("mis1_player", 64'(player), 1);
        chk("mis1_face_up", 64'(face_up), 64'(m_matched));
        chk("mis1_busy", 64'(busy), 0);

        // select during SHOW is dropped
        push_turn(5, 22);
        pick(5);
        wait_ready("mis2_a");
        pick(22);
        wait_mismatch("mis2");
        @(negedge clock);
        cursor = 6'd7;
        select = 1'b1;
        @(negedge clock);
        select = 1'b0;
        chk("show_sel_rd_addr", 64'(rd_addr), 22);
        chk("show_sel_busy", 64'(busy), 1);
        wait_ready("mis2_b");
        @(negedge clock);
        chk("show_sel_after_busy", 64'(busy), 0);
        chk("show_sel_after_addr", 64'(rd_addr), 22);
        chk("mis2_player", 64'(player), 0);

        illegal(40, "ill_range");
        illegal(3, "ill_matched1");
        push_turn(0, 2);
        pick(0);
        wait_ready("t02_a");
        illegal(0, "ill_same");
        illegal(20, "ill_matched2");
        illegal(36, "ill_range2");
        pick(2);
        wait_ready("t02_b");

        // rest of the game, a mismatch before every match but the last
        for (int k = 0; k < 16; k++) begin
            if (k < 15) turn(pa[k], pa[k + 1]);
            turn(pa[k], pb[k]);
        end
        @(negedge clock);
        chk("over_game_over", 64'(game_over), 1);
        chk("over_pairs", 64'(pairs_found), 18);
        chk("over_scores", 64'({score0, score1}), 64'({5'd9, 5'd9}));
        chk("over_sum", 64'(score0 + score1), 18);
        chk("over_matched", 64'(matched), 64'(36'hF_FFFF_FFFF));
        chk("over_busy", 64'(busy), 1);

        begin
            logic [5:0] a0;
            a0 = rd_addr;
            @(negedge clock);
            cursor = 6'd0;
            select = 1'b1;
            @(negedge clock);
            select = 1'b0;
            repeat (3) @(negedge clock);
            chk("over_sel_addr", 64'(rd_addr), 64'(a0));
            chk("over_sel_go", 64'(game_over), 1);
            chk("over_sel_pairs", 64'(pairs_found), 18);
        end

        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        chk_cleared("restart");
        model_clear();

        // async reset in the middle of SHOW
        push_turn(0, 1);
        pick(0);
        wait_ready("rst_a");
        pick(1);
        wait_mismatch("rst");
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk_cleared("async");
        @(negedge clock);
        reset_n = 1'b1;
        model_clear();

        // restart beats a simultaneous select
        @(negedge clock);
        cursor = 6'd3;
        select = 1'b1;
        restart = 1'b1;
        @(posedge clock);
        #1;
        chk("rs_sel_busy", 64'(busy), 0);
        chk("rs_sel_addr", 64'(rd_addr), 0);
        @(negedge clock);
        select = 1'b0;
        restart = 1'b0;
        repeat (3) @(negedge clock);
        chk("rs_sel_data1", 64'(data1), 0);
        chk("rs_sel_face_up", 64'(face_up), 0);

        chk("sb_drained", 64'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
